// File: rtl/branch_predictor_sa.sv
// ---------------------------------------------------------------------------
// branch_predictor_sa
//
// N-way set-associative branch target buffer with a 2-bit saturating
// direction counter per entry. Fetch looks up the predicted direction and
// target combinationally; Execute trains the tables with every resolved
// branch. Allocation happens only on a taken miss, so a set never holds two
// entries with the same tag.
//
// Ports:
//   clk            rising-edge clock
//   RESET          asynchronous reset, active low
//   PC_F           fetch PC to look up
//   PrPCSrc_F      predicted taken (hit and counter MSB set)
//   PrALUResult_F  predicted target, 0 when not predicted taken
//   BrValid_E      a branch resolves in Execute this cycle
//   PC_E           PC of the resolving branch
//   PCSrc_E        actual direction (1 = taken)
//   ALUResult_E    actual target
//   PrPCSrc_E      prediction originally made for the resolving branch
//   Flush          clear every valid bit at the next edge
//   BrCount        resolved-branch count (0 unless BP_PERF_CNT_EN)
//   MispCount      direction-mispredict count (0 unless BP_PERF_CNT_EN)
//
// Optional feature macro: BP_PERF_CNT_EN builds the two performance
// counters; without it the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module branch_predictor_sa #(
  parameter int         SET_BITS = 3,
  parameter int         WAYS     = 2,
  parameter int         TAG_W    = 30 - SET_BITS,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] PC_F,
  output logic        PrPCSrc_F,
  output logic [31:0] PrALUResult_F,
  input  logic        BrValid_E,
  input  logic [31:0] PC_E,
  input  logic        PCSrc_E,
  input  logic [31:0] ALUResult_E,
  input  logic        PrPCSrc_E,
  input  logic        Flush,
  output logic [31:0] BrCount,
  output logic [31:0] MispCount
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Entry storage, indexed [set][way]
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-1:0]  valid_d  [SETS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [TAG_W-1:0] tag_d    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [31:0]      target_d [SETS][WAYS];
  logic [1:0]       cnt_q    [SETS][WAYS];
  logic [1:0]       cnt_d    [SETS][WAYS];
  logic [PTR_W-1:0] ptr_q    [SETS];
  logic [PTR_W-1:0] ptr_d    [SETS];

  logic [SET_BITS-1:0] f_set;
  logic [TAG_W-1:0]    f_tag;
  logic                f_hit;
  logic                f_msb;
  logic [31:0]         f_target;

  logic [SET_BITS-1:0] e_set;
  logic [TAG_W-1:0]    e_tag;
  logic                e_hit;
  logic [PTR_W-1:0]    e_hit_way;
  logic                e_any_inv;
  logic [PTR_W-1:0]    e_inv_way;
  logic [PTR_W-1:0]    e_victim;

  // PC[1:0] never participate in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

  assign f_set = PC_F[SET_BITS+1:2];
  assign f_tag = PC_F[31:SET_BITS+2];
  assign e_set = PC_E[SET_BITS+1:2];
  assign e_tag = PC_E[31:SET_BITS+2];

  // Fetch lookup reads the registered tables only, so a same-cycle update
  // to the same set becomes visible one cycle later.
  always_comb begin
    f_hit    = 1'b0;
    f_msb    = 1'b0;
    f_target = 32'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (!f_hit && valid_q[f_set][w] && (tag_q[f_set][w] == f_tag)) begin
        f_hit    = 1'b1;
        f_msb    = cnt_q[f_set][w][1];
        f_target = target_q[f_set][w];
      end
    end
  end

  assign PrPCSrc_F     = f_hit & f_msb;
  assign PrALUResult_F = PrPCSrc_F ? f_target : 32'd0;

  // Execute-side hit detection and victim choice. The downward scan leaves
  // the lowest-numbered invalid way in e_inv_way.
  always_comb begin
    e_hit     = 1'b0;
    e_hit_way = '0;
    e_any_inv = 1'b0;
    e_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!e_hit && valid_q[e_set][w] && (tag_q[e_set][w] == e_tag)) begin
        e_hit     = 1'b1;
        e_hit_way = PTR_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[e_set][w]) begin
        e_any_inv = 1'b1;
        e_inv_way = PTR_W'(w);
      end
    end
    e_victim = e_any_inv ? e_inv_way : ptr_q[e_set];
  end

  // Table next state. Flush takes priority and suppresses any training in
  // the same cycle; it touches nothing but the valid bits.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    if (Flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
      end
    end else if (BrValid_E) begin
      if (e_hit) begin
        if (PCSrc_E) begin
          if (cnt_q[e_set][e_hit_way] != 2'b11) begin
            cnt_d[e_set][e_hit_way] = cnt_q[e_set][e_hit_way] + 2'b01;
          end
          target_d[e_set][e_hit_way] = ALUResult_E;
        end else if (cnt_q[e_set][e_hit_way] != 2'b00) begin
          cnt_d[e_set][e_hit_way] = cnt_q[e_set][e_hit_way] - 2'b01;
        end
      end else if (PCSrc_E) begin
        valid_d[e_set][e_victim]  = 1'b1;
        tag_d[e_set][e_victim]    = e_tag;
        target_d[e_set][e_victim] = ALUResult_E;
        cnt_d[e_set][e_victim]    = CNT_INIT;
        // The pointer only moves when it actually chose the victim
        if (!e_any_inv) begin
          ptr_d[e_set] = ptr_q[e_set] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]    <= '0;
          target_q[s][w] <= 32'd0;
          cnt_q[s][w]    <= CNT_INIT;
        end
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Round-robin pointers exist only when there is a choice of way
  generate
    if (WAYS > 1) begin : g_ptr
      always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
          for (int s = 0; s < SETS; s++) begin
            ptr_q[s] <= '0;
          end
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end else begin : g_no_ptr
      always_comb begin
        for (int s = 0; s < SETS; s++) begin
          ptr_q[s] = '0;
        end
      end
    end
  endgenerate

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_count_q;
  logic [31:0] br_count_d;
  logic [31:0] misp_count_q;
  logic [31:0] misp_count_d;

  // Performance counters wrap naturally and ignore Flush
  always_comb begin
    br_count_d   = br_count_q;
    misp_count_d = misp_count_q;
    if (BrValid_E) begin
      br_count_d = br_count_q + 32'd1;
      if (PrPCSrc_E != PCSrc_E) begin
        misp_count_d = misp_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      br_count_q   <= 32'd0;
      misp_count_q <= 32'd0;
    end else begin
      br_count_q   <= br_count_d;
      misp_count_q <= misp_count_d;
    end
  end

  assign BrCount   = br_count_q;
  assign MispCount = misp_count_q;
`else
  logic unused_pred_e;
  assign unused_pred_e = PrPCSrc_E;
  assign BrCount       = 32'd0;
  assign MispCount     = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor_sa.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_sa
//
// Directed bench for branch_predictor_sa with default parameters
// (8 sets, 2 ways, CNT_INIT = 2'b10). Expected values are worked out by hand
// from the counter/allocation rules; the performance counters are tracked by
// a running tally of the branches the bench resolves.
// ---------------------------------------------------------------------------
module tb_branch_predictor_sa;

  logic        clk;
  logic        RESET;
  logic [31:0] PC_F;
  logic        PrPCSrc_F;
  logic [31:0] PrALUResult_F;
  logic        BrValid_E;
  logic [31:0] PC_E;
  logic        PCSrc_E;
  logic [31:0] ALUResult_E;
  logic        PrPCSrc_E;
  logic        Flush;
  logic [31:0] BrCount;
  logic [31:0] MispCount;

  int compareCount = 0;
  int failCount    = 0;
  int expBr        = 0;
  int expMisp      = 0;

  branch_predictor_sa dut (
    .clk           (clk),
    .RESET         (RESET),
    .PC_F          (PC_F),
    .PrPCSrc_F     (PrPCSrc_F),
    .PrALUResult_F (PrALUResult_F),
    .BrValid_E     (BrValid_E),
    .PC_E          (PC_E),
    .PCSrc_E       (PCSrc_E),
    .ALUResult_E   (ALUResult_E),
    .PrPCSrc_E     (PrPCSrc_E),
    .Flush         (Flush),
    .BrCount       (BrCount),
    .MispCount     (MispCount)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one Execute-stage event across a single rising edge
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic taken, input logic [31:0] target,
                               input logic pred, input logic flush);
    @(negedge clk);
    BrValid_E   = valid;
    PC_E        = pc;
    PCSrc_E     = taken;
    ALUResult_E = target;
    PrPCSrc_E   = pred;
    Flush       = flush;
    if (valid) begin
      expBr++;
      if (pred != taken) expMisp++;
    end
    @(posedge clk);
    #1;
    BrValid_E = 1'b0;
    Flush     = 1'b0;
  endtask

  task automatic checkLookup(input string tag, input logic [31:0] pc,
                             input logic expTaken, input logic [31:0] expTarget);
    PC_F = pc;
    #1;
    checkOutput({tag, ".taken"}, {31'd0, PrPCSrc_F}, {31'd0, expTaken});
    checkOutput({tag, ".target"}, PrALUResult_F, expTarget);
  endtask

  task automatic checkPerf(input string tag);
`ifdef BP_PERF_CNT_EN
    checkOutput({tag, ".BrCount"}, BrCount, 32'(expBr));
    checkOutput({tag, ".MispCount"}, MispCount, 32'(expMisp));
`else
    checkOutput({tag, ".BrCount"}, BrCount, 32'd0);
    checkOutput({tag, ".MispCount"}, MispCount, 32'd0);
`endif
  endtask

  initial begin
    RESET       = 1'b0;
    PC_F        = 32'h100;
    BrValid_E   = 1'b0;
    PC_E        = 32'd0;
    PCSrc_E     = 1'b0;
    ALUResult_E = 32'd0;
    PrPCSrc_E   = 1'b0;
    Flush       = 1'b0;

    // Reset state
    #2;
    checkLookup("reset_lookup", 32'h100, 1'b0, 32'h0);
    checkPerf("reset_perf");
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b1;
    checkLookup("post_reset", 32'h100, 1'b0, 32'h0);

    // Allocation on a taken miss, counter starts at weak taken
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
    checkLookup("alloc_hit", 32'h40, 1'b1, 32'h80);
    checkLookup("other_set", 32'h44, 1'b0, 32'h0);

    // 10 -> 01 (not taken), then back to 10 with a fresh target
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    checkLookup("cnt_01", 32'h40, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h88, 1'b0, 1'b0);
    checkLookup("cnt_10_newtgt", 32'h40, 1'b1, 32'h88);

    // Upper saturation: 10 -> 11 -> 11, then one NT leaves 10 (still taken)
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h88, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h88, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    checkLookup("sat_high", 32'h40, 1'b1, 32'h88);

    // Lower saturation: 10 -> 01 -> 00 -> 00, then two takens back to 10
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    checkLookup("sat_low", 32'h40, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h90, 1'b0, 1'b0);
    checkLookup("cnt_01_again", 32'h40, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h90, 1'b0, 1'b0);
    checkLookup("cnt_10_again", 32'h40, 1'b1, 32'h90);

    // Not-taken miss allocates nothing; an invalid branch changes nothing
    applyStimulus(1'b1, 32'h48, 1'b0, 32'h100, 1'b0, 1'b0);
    checkLookup("miss_nt", 32'h48, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'hC4, 1'b1, 32'h300, 1'b0, 1'b0);
    checkLookup("no_valid", 32'hC4, 1'b0, 32'h0);

    // Lookup and update to the same entry in one cycle: no bypass
    @(negedge clk);
    PC_F        = 32'h0C;
    BrValid_E   = 1'b1;
    PC_E        = 32'h0C;
    PCSrc_E     = 1'b1;
    ALUResult_E = 32'h200;
    PrPCSrc_E   = 1'b0;
    expBr++;
    expMisp++;
    #1;
    checkOutput("no_bypass.taken", {31'd0, PrPCSrc_F}, 32'd0);
    @(posedge clk);
    #1;
    BrValid_E = 1'b0;
    checkLookup("after_same_cycle", 32'h0C, 1'b1, 32'h200);

    // Flush alone, then round-robin replacement in set 0
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkLookup("flush_40", 32'h40, 1'b0, 32'h0);
    checkLookup("flush_0c", 32'h0C, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h140, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h60, 1'b1, 32'h160, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 1'b0);
    checkLookup("rr_60", 32'h60, 1'b1, 32'h160);
    checkLookup("rr_80", 32'h80, 1'b1, 32'h180);
    checkLookup("rr_40_evicted", 32'h40, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hA0, 1'b1, 32'h1A0, 1'b0, 1'b0);
    checkLookup("rr_60_evicted", 32'h60, 1'b0, 32'h0);
    checkLookup("rr_80_kept", 32'h80, 1'b1, 32'h180);
    checkLookup("rr_a0", 32'hA0, 1'b1, 32'h1A0);

    // Flush wins over a simultaneous taken update
    applyStimulus(1'b1, 32'h20, 1'b1, 32'h220, 1'b0, 1'b1);
    checkLookup("flush_upd_20", 32'h20, 1'b0, 32'h0);
    checkLookup("flush_upd_80", 32'h80, 1'b0, 32'h0);
    checkLookup("flush_upd_a0", 32'hA0, 1'b0, 32'h0);

    checkPerf("perf_totals");

    // Asynchronous reset clears outputs at once and aborts a pending write
    applyStimulus(1'b1, 32'h28, 1'b1, 32'h228, 1'b0, 1'b0);
    checkLookup("pre_reset_28", 32'h28, 1'b1, 32'h228);
    @(negedge clk);
    BrValid_E   = 1'b1;
    PC_E        = 32'h24;
    PCSrc_E     = 1'b1;
    ALUResult_E = 32'h224;
    PrPCSrc_E   = 1'b0;
    RESET       = 1'b0;
    expBr       = 0;
    expMisp     = 0;
    checkLookup("async_reset_28", 32'h28, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    BrValid_E = 1'b0;
    checkPerf("reset_perf_again");
    @(negedge clk);
    RESET = 1'b1;
    checkLookup("aborted_24", 32'h24, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
